// File: rtl/div32_seq_pkg.sv
// Shared definitions for the sequential MIPS DIV/DIVU divider.
package div32_seq_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_t;

  localparam int unsigned DIV_ITER = 32;
  localparam logic [31:0] DIV_DZ_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/cla32.sv
// 32-bit adder: ripple inside 4-bit groups, lookahead carry between groups.
module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [8:0]  gc;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    c  = '0;
    gc = '0;
    gc[0] = ci;
    for (int unsigned k = 0; k < 8; k++) begin
      c[4*k] = gc[k];
      for (int unsigned j = 1; j < 4; j++) begin
        c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
      end
      gc[k+1] = g[4*k+3]
              | (p[4*k+3] & g[4*k+2])
              | (p[4*k+3] & p[4*k+2] & g[4*k+1])
              | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
              | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    s  = p ^ c;
    co = gc[8];
  end

endmodule

// File: rtl/div32_seq.sv
// Restoring divider for MIPS DIV/DIVU: one quotient bit per cycle, HI=r, LO=q.
module div32_seq
  import div32_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  localparam logic [5:0] ITER_CNT = 6'(DIV_ITER);

  div_state_t       state;
  logic [5:0]       cnt;
  logic             neg_q;
  logic             neg_r;
  logic             dz;
  logic [WIDTH-1:0] a_orig;
  logic [WIDTH-1:0] bmag;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             co;
  logic             no_borrow;
  logic [WIDTH-1:0] next_rem;

  // Trial subtraction: shifted - |b| as shifted + ~|b| + 1; carry-out means no borrow.
  cla32 u_sub (
    .a  (shifted[WIDTH-1:0]),
    .b  (~bmag),
    .ci (1'b1),
    .s  (trial),
    .co (co)
  );

  always_comb begin
    shifted   = {rem, dvd[WIDTH-1]};
    no_borrow = co | shifted[WIDTH];
    next_rem  = no_borrow ? trial : shifted[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state  <= DIV_IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      ready  <= 1'b0;
      q      <= '0;
      r      <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      a_orig <= '0;
      bmag   <= '0;
      rem    <= '0;
      dvd    <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        DIV_IDLE: begin
          if (start) begin
            neg_q  <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= sign & a[WIDTH-1];
            dz     <= (b == '0);
            a_orig <= a;
            dvd    <= (sign && a[WIDTH-1]) ? -a : a;
            bmag   <= (sign && b[WIDTH-1]) ? -b : b;
            rem    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= DIV_CALC;
          end
        end
        DIV_CALC: begin
          // 32 iterations, then one settle cycle keeps the fixed 34-cycle latency.
          if (cnt < ITER_CNT) begin
            rem <= next_rem;
            dvd <= {dvd[WIDTH-2:0], no_borrow};
            cnt <= cnt + 6'd1;
          end else begin
            state <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          if (dz) begin
            q <= DIV_DZ_Q;
            r <= a_orig;
          end else begin
            q <= neg_q ? -dvd : dvd;
            r <= neg_r ? -rem : rem;
          end
          busy  <= 1'b0;
          ready <= 1'b1;
          state <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule
